// File: rtl/iecdrv_pkg.sv
// rtl/iecdrv_pkg.sv - shared types and SD field widths for the IEC drive blocks
package iecdrv_pkg;

  localparam int SD_LBA_W = 32;
  localparam int SD_BLK_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    DONE
  } sdarb_state_t;

endpackage

// File: rtl/iecdrv_rr_pick.sv
// rtl/iecdrv_rr_pick.sv - round-robin priority encoder starting at ptr
module iecdrv_rr_pick
  import iecdrv_pkg::*;
#(
  parameter int NDRIVES = 4,
  parameter int IDX_W   = (NDRIVES > 1) ? $clog2(NDRIVES) : 1
) (
  input  logic [NDRIVES-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   index
);

  logic [IDX_W-1:0] cand;

  // Walk candidates ptr, ptr+1, ... modulo NDRIVES; the first requester sticks.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = ptr;
    for (int k = 0; k < NDRIVES; k++) begin
      if (!valid && req[cand]) begin
        valid = 1'b1;
        index = cand;
      end
      cand = (cand == IDX_W'(NDRIVES - 1)) ? '0 : cand + 1'b1;
    end
  end

endmodule

// File: rtl/iecdrv_sd_arbiter.sv
// rtl/iecdrv_sd_arbiter.sv - round-robin arbiter of drive SD requests onto one host port
module iecdrv_sd_arbiter
  import iecdrv_pkg::*;
#(
  parameter int NDRIVES   = 4,
  parameter int TIMEOUT_W = 24
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic [NDRIVES*SD_LBA_W-1:0]  drv_sd_lba,
  input  logic [NDRIVES*SD_BLK_W-1:0]  drv_sd_blk_cnt,
  input  logic [NDRIVES-1:0]           drv_sd_rd,
  input  logic [NDRIVES-1:0]           drv_sd_wr,
  output logic [NDRIVES-1:0]           drv_sd_ack,
  output logic [NDRIVES-1:0]           drv_sd_buff_wr,
  input  logic [NDRIVES*8-1:0]         drv_sd_buff_din,
  output logic [SD_LBA_W-1:0]          sd_lba,
  output logic [SD_BLK_W-1:0]          sd_blk_cnt,
  output logic                         sd_rd,
  output logic                         sd_wr,
  input  logic                         sd_ack,
  input  logic                         sd_buff_wr,
  output logic [7:0]                   sd_buff_din,
  output logic                         busy,
  output logic                         timeout
);

  localparam int IDX_W = (NDRIVES > 1) ? $clog2(NDRIVES) : 1;

  sdarb_state_t         state;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     owner;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_valid;
  logic [TIMEOUT_W-1:0] wdog;
  logic [TIMEOUT_W-1:0] wdog_inc;

  logic [SD_LBA_W-1:0]  lba_a [NDRIVES];
  logic [SD_BLK_W-1:0]  blk_a [NDRIVES];
  logic [7:0]           din_a [NDRIVES];

  for (genvar i = 0; i < NDRIVES; i++) begin : g_unpack
    assign lba_a[i] = drv_sd_lba[i*SD_LBA_W +: SD_LBA_W];
    assign blk_a[i] = drv_sd_blk_cnt[i*SD_BLK_W +: SD_BLK_W];
    assign din_a[i] = drv_sd_buff_din[i*8 +: 8];
  end

  iecdrv_rr_pick #(
    .NDRIVES (NDRIVES),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (drv_sd_rd | drv_sd_wr),
    .ptr   (ptr),
    .valid (pick_valid),
    .index (pick_idx)
  );

  assign wdog_inc    = wdog + 1'b1;
  assign sd_buff_din = din_a[owner];

  // The REQ cycle that sees sd_ack is routed too, so a strobe there is not dropped.
  always_comb begin
    drv_sd_ack     = '0;
    drv_sd_buff_wr = '0;
    if (state == XFER || (state == REQ && sd_ack)) begin
      drv_sd_ack[owner]     = sd_ack;
      drv_sd_buff_wr[owner] = sd_buff_wr;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      wdog       <= '0;
      sd_lba     <= '0;
      sd_blk_cnt <= '0;
      sd_rd      <= 1'b0;
      sd_wr      <= 1'b0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner      <= pick_idx;
            sd_lba     <= lba_a[pick_idx];
            sd_blk_cnt <= blk_a[pick_idx];
            sd_wr      <= drv_sd_wr[pick_idx];
            sd_rd      <= !drv_sd_wr[pick_idx];
            wdog       <= '0;
            busy       <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (sd_ack) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            state <= XFER;
          end else begin
            wdog <= wdog_inc;
            if (wdog_inc == '1) begin
              timeout <= 1'b1;
              sd_rd   <= 1'b0;
              sd_wr   <= 1'b0;
              state   <= DONE;
            end
          end
        end
        XFER: begin
          if (!sd_ack) state <= DONE;
        end
        DONE: begin
          ptr   <= (owner == IDX_W'(NDRIVES - 1)) ? '0 : owner + 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iecdrv_sd_arbiter.sv
// tb/tb_iecdrv_sd_arbiter.sv - directed vector bench for iecdrv_sd_arbiter
module tb_iecdrv_sd_arbiter;

  localparam int N = 4;

  logic           clk_sys = 1'b0;
  logic           reset;
  logic [N*32-1:0] drv_sd_lba;
  logic [N*6-1:0]  drv_sd_blk_cnt;
  logic [N-1:0]   drv_sd_rd, drv_sd_wr, drv_sd_ack, drv_sd_buff_wr;
  logic [N*8-1:0] drv_sd_buff_din;
  logic [31:0]    sd_lba;
  logic [5:0]     sd_blk_cnt;
  logic           sd_rd, sd_wr, sd_ack, sd_buff_wr;
  logic [7:0]     sd_buff_din;
  logic           busy, timeout;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] rd;
    logic       ack;
    logic       bw;
    logic       e_rd;
    logic       e_busy;
    logic [3:0] e_ack;
    logic [3:0] e_bw;
  } vec_t;

  vec_t tab[14];

  always #5 clk_sys = ~clk_sys;

  iecdrv_sd_arbiter #(
    .NDRIVES   (N),
    .TIMEOUT_W (4)
  ) dut (
    .clk_sys         (clk_sys),
    .reset           (reset),
    .drv_sd_lba      (drv_sd_lba),
    .drv_sd_blk_cnt  (drv_sd_blk_cnt),
    .drv_sd_rd       (drv_sd_rd),
    .drv_sd_wr       (drv_sd_wr),
    .drv_sd_ack      (drv_sd_ack),
    .drv_sd_buff_wr  (drv_sd_buff_wr),
    .drv_sd_buff_din (drv_sd_buff_din),
    .sd_lba          (sd_lba),
    .sd_blk_cnt      (sd_blk_cnt),
    .sd_rd           (sd_rd),
    .sd_wr           (sd_wr),
    .sd_ack          (sd_ack),
    .sd_buff_wr      (sd_buff_wr),
    .sd_buff_din     (sd_buff_din),
    .busy            (busy),
    .timeout         (timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_grant(input string name);
    int k;
    k = 0;
    while (!(sd_rd || sd_wr) && k < 20) begin
      tick();
      k++;
    end
    chk({name, " grant"}, 32'(sd_rd || sd_wr), 32'd1);
  endtask

  task automatic host_xfer(input int n);
    sd_ack = 1'b1;
    repeat (n) tick();
    sd_ack = 1'b0;
    tick();
    tick();
  endtask

  function automatic vec_t mk(input logic [3:0] rd, input logic ack, input logic bw,
                              input logic e_rd, input logic e_busy,
                              input logic [3:0] e_ack, input logic [3:0] e_bw);
    vec_t v;
    v.rd = rd; v.ack = ack; v.bw = bw;
    v.e_rd = e_rd; v.e_busy = e_busy; v.e_ack = e_ack; v.e_bw = e_bw;
    return v;
  endfunction

  initial begin
    int order[5];
    order = '{0, 1, 2, 3, 0};

    // Single read by drive 1: 10 ack cycles, strobes on even vectors, ack drop, 2-cycle tail.
    tab[0] = mk(4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000);
    tab[1] = mk(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0010, 4'b0000);
    for (int i = 2; i <= 10; i++)
      tab[i] = mk(4'b0000, 1'b1, (i % 2 == 0), 1'b0, 1'b1, 4'b0010,
                  (i % 2 == 0) ? 4'b0010 : 4'b0000);
    tab[11] = mk(4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000);
    tab[12] = mk(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    tab[13] = mk(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);

    drv_sd_lba      = {32'h300, 32'h200, 32'h120, 32'h100};
    drv_sd_blk_cnt  = {6'd63, 6'd7, 6'd31, 6'd1};
    drv_sd_buff_din = {8'h3C, 8'hA5, 8'h21, 8'h10};
    drv_sd_rd = '0; drv_sd_wr = '0;
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    chk("reset sd_rd", sd_rd, 0);
    chk("reset sd_wr", sd_wr, 0);
    chk("reset busy", busy, 0);
    chk("reset timeout", timeout, 0);
    chk("reset sd_lba", sd_lba, 0);
    chk("reset sd_blk_cnt", sd_blk_cnt, 0);
    chk("reset drv_sd_ack", drv_sd_ack, 0);
    chk("reset sd_buff_din", sd_buff_din, 32'h10);
    reset = 1'b0;

    // Round robin with all four drives requesting continuously
    drv_sd_rd = 4'hF;
    for (int g = 0; g < 5; g++) begin
      wait_grant($sformatf("rr%0d", g));
      chk($sformatf("rr%0d lba", g), sd_lba, (order[g] == 0) ? 32'h100 :
          (order[g] == 1) ? 32'h120 : (order[g] == 2) ? 32'h200 : 32'h300);
      sd_ack = 1'b1;
      #1;
      chk($sformatf("rr%0d owner", g), drv_sd_ack, 32'(1 << order[g]));
      if (g == 4) drv_sd_rd = '0;
      repeat (2) tick();
      sd_ack = 1'b0;
      tick();
      tick();
    end

    // Write beats read within a drive; buffer data and transition-cycle strobe routing
    drv_sd_rd = 4'b0100; drv_sd_wr = 4'b0100;
    tick();
    chk("wp sd_wr", sd_wr, 1);
    chk("wp sd_rd", sd_rd, 0);
    chk("wp sd_buff_din", sd_buff_din, 32'hA5);
    chk("wp sd_blk_cnt", sd_blk_cnt, 7);
    sd_ack = 1'b1; sd_buff_wr = 1'b1;
    #1;
    chk("wp req-cycle buff_wr", drv_sd_buff_wr, 32'b0100);
    drv_sd_rd = '0; drv_sd_wr = '0;
    tick();
    chk("wp sd_wr drop", sd_wr, 0);
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    tick();
    tick();
    chk("wp idle busy", busy, 0);

    // Single read table
    for (int i = 0; i < 14; i++) begin
      drv_sd_rd = tab[i].rd; sd_ack = tab[i].ack; sd_buff_wr = tab[i].bw;
      tick();
      chk($sformatf("sr v%0d sd_rd", i), sd_rd, tab[i].e_rd);
      chk($sformatf("sr v%0d busy", i), busy, tab[i].e_busy);
      chk($sformatf("sr v%0d drv_sd_ack", i), drv_sd_ack, tab[i].e_ack);
      chk($sformatf("sr v%0d drv_sd_buff_wr", i), drv_sd_buff_wr, tab[i].e_bw);
    end
    chk("sr sd_lba", sd_lba, 32'h120);
    chk("sr sd_blk_cnt", sd_blk_cnt, 31);
    sd_buff_wr = 1'b0;

    // ptr is 2 now: drives 0 and 3 request, 3 wins
    drv_sd_rd = 4'b1001;
    tick();
    chk("sim sd_lba", sd_lba, 32'h300);
    drv_sd_rd = '0;
    host_xfer(2);

    // Watchdog: drive 0 never acked, request dropped while waiting
    drv_sd_rd = 4'b0001;
    tick();
    chk("wd grant", sd_rd, 1);
    chk("wd sd_lba", sd_lba, 32'h100);
    drv_sd_rd = '0;
    repeat (14) tick();
    chk("wd held 14", sd_rd, 1);
    chk("wd no early pulse", timeout, 0);
    tick();
    chk("wd timeout", timeout, 1);
    chk("wd sd_rd drop", sd_rd, 0);
    drv_sd_rd = 4'b0011;
    tick();
    chk("wd pulse width", timeout, 0);
    chk("wd idle busy", busy, 0);
    tick();
    chk("wd next grant", sd_lba, 32'h120);
    drv_sd_rd = '0;
    host_xfer(2);

    // Reset in the middle of a transfer
    drv_sd_rd = 4'b0100;
    tick();
    drv_sd_rd = '0;
    sd_ack = 1'b1;
    tick();
    chk("rst xfer ack", drv_sd_ack, 32'b0100);
    reset = 1'b1;
    tick();
    chk("rst drv_sd_ack", drv_sd_ack, 0);
    chk("rst sd_rd", sd_rd, 0);
    chk("rst busy", busy, 0);
    reset = 1'b0; sd_ack = 1'b0;
    drv_sd_rd = 4'b1001;
    tick();
    chk("rst first owner", sd_lba, 32'h100);
    drv_sd_rd = '0;
    host_xfer(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
